div_seq: RTL

Sequential signed divider: the inverse of the ALU's 16×16→32 signed multiplier. It takes a 2W-bit signed dividend and a W-bit signed divisor and returns a W-bit quotient and a W-bit remainder. It uses a restoring shift-subtract loop that processes one bit per cycle. It sits in the multi-cycle CPU's ALU next to the multiplier and uses the same `start`-pulse control style, so the control FSM can wait on `done`.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/div_step.sv | 29 ++
 rtl/div_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: types and constants shared by the multi-cycle ALU blocks (divider state
// encoding, datapath width, iteration counter width).
package alu_pkg;

    // Default ALU datapath width; the divider's divisor/quotient/remainder width.
    localparam int ALU_W = 16;

    // Counter width needed to count 2*w shift-subtract iterations (0 .. 2*w-1).
    function automatic int div_cnt_w(input int w);
        return (w < 1) ? 1 : $clog2(2 * w);
    endfunction

    localparam int DIV_CNT_W = div_cnt_w(ALU_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step. Shifts the next dividend
// bit into the partial remainder, subtracts |B| if it fits, and reports the
// resulting quotient bit.
module div_step
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic [2*W:0]   rem_in,
    input  logic           dividend_bit,
    input  logic [W-1:0]   divisor,
    output logic [2*W:0]   rem_out,
    output logic           q_bit
);

    localparam int RW = 2 * W + 1;

    logic [2*W+1:0] shifted;
    logic [2*W+1:0] div_ext;

    // Shift, compare against |B| and keep the difference only when it is non-negative.
    always_comb begin
        shifted = {rem_in, dividend_bit};
        div_ext = {{(W + 2){1'b0}}, divisor};
        q_bit   = (shifted >= div_ext);
        rem_out = RW'(q_bit ? (shifted - div_ext) : shifted);
    end

endmodule

// File: rtl/div_seq.sv
// div_seq: sequential signed divider, 2W-bit dividend by W-bit divisor, one
// quotient bit per cycle via restoring shift-subtract on magnitudes, with the
// signs applied afterwards (quotient truncates toward zero, remainder follows A).
// Build option: define DIV_OVF_DETECT_EN to compute the overflow flag; otherwise
// overflow is tied low and Q is always the truncated quotient.
module div_seq
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] A,
    input  logic [W-1:0]   B,
    output logic [W-1:0]   Q,
    output logic [W-1:0]   R,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CNT_W = div_cnt_w(W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * W - 1);

    div_state_t state_reg;
    div_state_t state_next;

    // Partial remainder (2W+1 bits) and dividend shift register. The dividend
    // register shifts its MSB into the remainder each step and takes the new
    // quotient bit at its LSB, so after 2W steps it holds |quotient|.
    logic [2*W:0]     rem_reg;
    logic [2*W-1:0]   dvd_reg;
    logic [W-1:0]     b_mag_reg;
    logic             sign_a_reg;
    logic             neg_reg;
    logic             dbz_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [2*W:0]     step_rem;
    logic             step_q;
    logic [2*W-1:0]   a_mag;
    logic [W-1:0]     b_mag;
    logic             b_zero;
    logic [W-1:0]     q_signed;
    logic [W-1:0]     r_signed;
    logic             ovf;

    div_step #(
        .W (W)
    ) u_step (
        .rem_in       (rem_reg),
        .dividend_bit (dvd_reg[2*W-1]),
        .divisor      (b_mag_reg),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    // Operand magnitudes taken at acceptance.
    always_comb begin
        a_mag  = A[2*W-1] ? (~A + 1'b1) : A;
        b_mag  = B[W-1] ? (~B + 1'b1) : B;
        b_zero = (B == '0);
    end

    // Sign fix-up of the magnitude results; only the low W quotient bits are kept,
    // which is also what an overflowing quotient reports.
    always_comb begin
        q_signed = neg_reg ? (~dvd_reg[W-1:0] + 1'b1) : dvd_reg[W-1:0];
        r_signed = sign_a_reg ? (~rem_reg[W-1:0] + 1'b1) : rem_reg[W-1:0];
    end

`ifdef DIV_OVF_DETECT_EN
    localparam logic [2*W-1:0] POS_MAX = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic [2*W-1:0] NEG_MAX = {{W{1'b0}}, 1'b1, {(W - 1){1'b0}}};

    // Quotient magnitude must fit the signed W-bit range for the result's sign.
    always_comb begin
        ovf = neg_reg ? (dvd_reg > NEG_MAX) : (dvd_reg > POS_MAX);
    end
`else
    // Overflow detection not built: the truncated quotient is reported silently.
    always_comb begin
        ovf = 1'b0;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and status decode. Divide-by-zero skips CALC and goes through FIX
    // so its fixed result is published one edge after acceptance.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = b_zero ? FIX : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, one restoring step per CALC cycle, result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_reg     <= '0;
            dvd_reg     <= '0;
            b_mag_reg   <= '0;
            sign_a_reg  <= 1'b0;
            neg_reg     <= 1'b0;
            dbz_reg     <= 1'b0;
            cnt_reg     <= '0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sign_a_reg <= A[2*W-1];
                        neg_reg    <= A[2*W-1] ^ B[W-1];
                        b_mag_reg  <= b_mag;
                        dbz_reg    <= b_zero;
                        // A zero divisor keeps A raw so FIX can return its low half.
                        dvd_reg    <= b_zero ? A : a_mag;
                        rem_reg    <= '0;
                        cnt_reg    <= '0;
                    end
                end
                CALC: begin
                    rem_reg <= step_rem;
                    dvd_reg <= {dvd_reg[2*W-2:0], step_q};
                    cnt_reg <= cnt_reg + 1'b1;
                end
                FIX: begin
                    if (dbz_reg) begin
                        Q           <= '1;
                        R           <= dvd_reg[W-1:0];
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else begin
                        Q           <= q_signed;
                        R           <= r_signed;
                        div_by_zero <= 1'b0;
                        overflow    <= ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
